// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - shared constants, FSM state type and cell indexing for the board checker
package sudoku_pkg;

    localparam int N_CELLS    = 81;
    localparam int N_GROUPS   = 27;
    localparam int GROUP_SIZE = 9;
    localparam int CELL_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    function automatic logic [6:0] cell_index(input logic [3:0] i, input logic [3:0] j);
        return 7'(i) * 7'd9 + 7'(j);
    endfunction

endpackage

// File: rtl/group_addr.sv
// rtl/group_addr.sv - maps (group, element) to the (row, column) of the cell being scanned
module group_addr
    import sudoku_pkg::*;
(
    input  logic [4:0] g,
    input  logic [3:0] e,
    output logic [3:0] i,
    output logic [3:0] j
);

    logic [4:0] b;
    logic [4:0] box_row;
    logic [4:0] box_col;

    always_comb begin
        b       = g - 5'(2 * GROUP_SIZE);
        box_row = b / 5'd3;
        box_col = b % 5'd3;
        i       = g[3:0];
        j       = e;
        // Boxes are walked row-major inside the 3x3 block.
        if (g >= 5'(2 * GROUP_SIZE)) begin
            i = 4'(box_row * 5'd3) + e / 4'd3;
            j = 4'(box_col * 5'd3) + e % 4'd3;
        end else if (g >= 5'(GROUP_SIZE)) begin
            i = e;
            j = 4'(g - 5'(GROUP_SIZE));
        end
    end

endmodule

// File: rtl/board_checker.sv
// rtl/board_checker.sv - snapshots a Sudoku board and scans rows, columns and boxes one cell per clock
module board_checker
    import sudoku_pkg::*;
#(
    parameter bit ABORT_ON_CONFLICT = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [N_CELLS*CELL_W-1:0]  board,
    input  logic [N_CELLS-1:0]         visibilities,
    output logic                       busy,
    output logic                       done,
    output logic                       complete,
    output logic                       conflict,
    output logic [4:0]                 conflict_group,
    output logic [3:0]                 conflict_i,
    output logic [3:0]                 conflict_j,
    output logic [6:0]                 filled_count
);

    state_t                      state;
    logic [N_CELLS*CELL_W-1:0]   snap_board;
    logic [N_CELLS-1:0]          snap_vis;
    logic [4:0]                  g;
    logic [3:0]                  e;
    logic [8:0]                  mask;

    logic [3:0]                  cur_i;
    logic [3:0]                  cur_j;
    logic [6:0]                  k;
    logic [3:0]                  v;
    logic [8:0]                  onehot;
    logic                        hit;
    logic                        count_inc;
    logic                        last;
    logic                        conflict_nxt;
    logic [6:0]                  filled_nxt;

    group_addr u_group_addr (
        .g (g),
        .e (e),
        .i (cur_i),
        .j (cur_j)
    );

    always_comb begin
        k            = cell_index(cur_i, cur_j);
        v            = snap_vis[k] ? snap_board[{k, 2'b00} +: CELL_W] : 4'd0;
        onehot       = (v != 4'd0 && v <= 4'd9) ? (9'd1 << (v - 4'd1)) : 9'd0;
        hit          = (v > 4'd9) || (|(mask & onehot));
        // Every cell appears in exactly one row group, so counting only there avoids triple counting.
        count_inc    = (g < 5'(GROUP_SIZE)) && (v != 4'd0);
        filled_nxt   = filled_count + 7'(count_inc);
        conflict_nxt = conflict || hit;
        last         = (g == 5'(N_GROUPS - 1) && e == 4'(GROUP_SIZE - 1))
                       || (ABORT_ON_CONFLICT && hit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            snap_board     <= '0;
            snap_vis       <= '0;
            g              <= '0;
            e              <= '0;
            mask           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            complete       <= 1'b0;
            conflict       <= 1'b0;
            conflict_group <= '0;
            conflict_i     <= '0;
            conflict_j     <= '0;
            filled_count   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        snap_board     <= board;
                        snap_vis       <= visibilities;
                        g              <= '0;
                        e              <= '0;
                        mask           <= '0;
                        complete       <= 1'b0;
                        conflict       <= 1'b0;
                        conflict_group <= '0;
                        conflict_i     <= '0;
                        conflict_j     <= '0;
                        filled_count   <= '0;
                        busy           <= 1'b1;
                        state          <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    filled_count <= filled_nxt;
                    conflict     <= conflict_nxt;
                    if (hit && !conflict) begin
                        conflict_group <= g;
                        conflict_i     <= cur_i;
                        conflict_j     <= cur_j;
                    end
                    if (last) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        complete <= !conflict_nxt && (filled_nxt == 7'(N_CELLS));
                        state    <= ST_DONE;
                    end else if (e == 4'(GROUP_SIZE - 1)) begin
                        mask <= '0;
                        e    <= '0;
                        g    <= g + 5'd1;
                    end else begin
                        mask <= mask | onehot;
                        e    <= e + 4'd1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_checker.sv
// tb/tb_board_checker.sv - self-checking bench for board_checker and group_addr
module tb_board_checker;

    typedef struct packed {
        logic       bs;
        logic       be;
        logic       clr;
        logic       conflict;
        logic       complete;
        logic [4:0] grp;
        logic [3:0] ci;
        logic [3:0] cj;
        logic [6:0] filled;
        logic [8:0] cyc;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         start;
    logic [323:0] board;
    logic [80:0]  visibilities;

    logic       a_busy, a_done, a_complete, a_conflict;
    logic [4:0] a_grp;
    logic [3:0] a_i, a_j;
    logic [6:0] a_filled;
    logic       n_busy, n_done, n_complete, n_conflict;
    logic [4:0] n_grp;
    logic [3:0] n_i, n_j;
    logic [6:0] n_filled;
    logic [4:0] ga_g;
    logic [3:0] ga_e, ga_i, ga_j;

    board_checker #(.ABORT_ON_CONFLICT(1'b1)) dut_abort (
        .clk(clk), .reset(reset), .start(start), .board(board), .visibilities(visibilities),
        .busy(a_busy), .done(a_done), .complete(a_complete), .conflict(a_conflict),
        .conflict_group(a_grp), .conflict_i(a_i), .conflict_j(a_j), .filled_count(a_filled)
    );

    board_checker #(.ABORT_ON_CONFLICT(1'b0)) dut_full (
        .clk(clk), .reset(reset), .start(start), .board(board), .visibilities(visibilities),
        .busy(n_busy), .done(n_done), .complete(n_complete), .conflict(n_conflict),
        .conflict_group(n_grp), .conflict_i(n_i), .conflict_j(n_j), .filled_count(n_filled)
    );

    group_addr dut_addr (.g(ga_g), .e(ga_e), .i(ga_i), .j(ga_j));

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] cells [81];
    bit         vis [81];
    res_t       obs_a, obs_n;

    function automatic string res_str(input res_t r);
        return $sformatf("busy0=%0d busy_end=%0d cleared=%0d conflict=%0d complete=%0d group=%0d i=%0d j=%0d filled=%0d done_cycle=%0d",
                         r.bs, r.be, r.clr, r.conflict, r.complete, r.grp, r.ci, r.cj, r.filled, r.cyc);
    endfunction

    function automatic res_t mk(input logic conf, input logic comp, input int grp, input int i,
                                input int j, input int filled, input int cyc);
        res_t r;
        r.bs = 1'b1; r.be = 1'b0; r.clr = 1'b1;
        r.conflict = conf; r.complete = comp;
        r.grp = 5'(grp); r.ci = 4'(i); r.cj = 4'(j);
        r.filled = 7'(filled); r.cyc = 9'(cyc);
        return r;
    endfunction

    // Reference: walk the 27 groups in rule order, tracking digits seen per group.
    function automatic res_t model(input bit abort);
        res_t r;
        bit   seen [10];
        bit   stop;
        int   filled, i, j, b, v;
        r = mk(1'b0, 1'b0, 0, 0, 0, 0, 244);
        stop = 0;
        filled = 0;
        for (int g = 0; g < 27 && !stop; g++) begin
            for (int d = 0; d < 10; d++) seen[d] = 0;
            for (int e = 0; e < 9 && !stop; e++) begin
                if (g < 9) begin
                    i = g; j = e;
                end else if (g < 18) begin
                    i = e; j = g - 9;
                end else begin
                    b = g - 18;
                    i = (b / 3) * 3 + e / 3;
                    j = (b % 3) * 3 + e % 3;
                end
                v = vis[i*9+j] ? int'(cells[i*9+j]) : 0;
                if (g < 9 && v != 0) filled++;
                if (v > 9 || (v != 0 && seen[v])) begin
                    if (!r.conflict) begin
                        r.conflict = 1'b1; r.grp = 5'(g); r.ci = 4'(i); r.cj = 4'(j);
                    end
                    if (abort) begin
                        stop = 1;
                        r.cyc = 9'(g * 9 + e + 2);
                    end
                end else if (v != 0) begin
                    seen[v] = 1;
                end
            end
        end
        r.filled = 7'(filled);
        r.complete = !r.conflict && filled == 81;
        return r;
    endfunction

    task automatic load_solved();
        int perm [9];
        int r, t;
        for (int d = 0; d < 9; d++) perm[d] = d + 1;
        for (int d = 8; d > 0; d--) begin
            r = $urandom_range(d, 0);
            t = perm[d]; perm[d] = perm[r]; perm[r] = t;
        end
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 9; j++) begin
                cells[i*9+j] = 4'(perm[(i*3 + i/3 + j) % 9]);
                vis[i*9+j] = 1;
            end
    endtask

    task automatic load_empty();
        for (int k = 0; k < 81; k++) begin
            cells[k] = 4'd0;
            vis[k] = 1;
        end
    endtask

    task automatic apply();
        for (int k = 0; k < 81; k++) begin
            board[4*k +: 4] = cells[k];
            visibilities[k] = vis[k];
        end
    endtask

    task automatic run_scan(input int extra_start);
        int c;
        bit seen_a, seen_n;
        apply();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        board = ~board;
        visibilities = ~visibilities;
        obs_a = '0;
        obs_n = '0;
        obs_a.bs = a_busy;
        obs_n.bs = n_busy;
        obs_a.clr = !a_conflict && !a_complete && a_filled == 0 && a_grp == 0 && a_i == 0 && a_j == 0;
        obs_n.clr = !n_conflict && !n_complete && n_filled == 0 && n_grp == 0 && n_i == 0 && n_j == 0;
        seen_a = 0;
        seen_n = 0;
        c = 0;
        while (!(seen_a && seen_n) && c < 400) begin
            @(posedge clk); #1 c++;
            if (a_done && !seen_a) begin
                seen_a = 1;
                obs_a.be = a_busy; obs_a.conflict = a_conflict; obs_a.complete = a_complete;
                obs_a.grp = a_grp; obs_a.ci = a_i; obs_a.cj = a_j; obs_a.filled = a_filled;
                obs_a.cyc = 9'(c + 1);
            end
            if (n_done && !seen_n) begin
                seen_n = 1;
                obs_n.be = n_busy; obs_n.conflict = n_conflict; obs_n.complete = n_complete;
                obs_n.grp = n_grp; obs_n.ci = n_i; obs_n.cj = n_j; obs_n.filled = n_filled;
                obs_n.cyc = 9'(c + 1);
            end
            start = (c == extra_start);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        vectors++;
        if ({a_busy, a_done, a_complete, a_conflict, a_grp, a_i, a_j, a_filled} !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_abort: outputs=%h expected 0", {a_busy, a_done, a_complete, a_conflict, a_grp, a_i, a_j, a_filled});
        end
        vectors++;
        if ({n_busy, n_done, n_complete, n_conflict, n_grp, n_i, n_j, n_filled} !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_full: outputs=%h expected 0", {n_busy, n_done, n_complete, n_conflict, n_grp, n_i, n_j, n_filled});
        end
        reset = 1'b1;
    endtask

    task automatic test_group_addr();
        int prev, i, j, k;
        bit ok, member;
        for (int g = 0; g < 27; g++) begin
            prev = -1;
            ok = 1;
            i = 0;
            j = 0;
            for (int e = 0; e < 9; e++) begin
                ga_g = 5'(g);
                ga_e = 4'(e);
                #1;
                i = int'(ga_i);
                j = int'(ga_j);
                if (i > 8 || j > 8) begin
                    ok = 0;
                end else begin
                    k = i * 9 + j;
                    if (k <= prev) ok = 0;
                    prev = k;
                    if (g < 9) member = (i == g);
                    else if (g < 18) member = (j == g - 9);
                    else member = ((i / 3) * 3 + j / 3 == g - 18);
                    if (!member) ok = 0;
                end
            end
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL group_addr g=%0d: last cell (%0d,%0d) not a row-major member of its group", g, i, j);
            end
        end
    endtask

    task automatic test_solved_grid();
        res_t exp;
        load_solved();
        run_scan(-1);
        exp = mk(1'b0, 1'b1, 0, 0, 0, 81, 244);
        vectors++;
        if (obs_a !== exp) begin miscompares++; $display("FAIL solved_abort: got %s expected %s", res_str(obs_a), res_str(exp)); end
        vectors++;
        if (obs_n !== exp) begin miscompares++; $display("FAIL solved_full: got %s expected %s", res_str(obs_n), res_str(exp)); end
    endtask

    task automatic test_hidden_cell();
        res_t exp;
        load_solved();
        vis[40] = 0;
        run_scan(-1);
        exp = mk(1'b0, 1'b0, 0, 0, 0, 80, 244);
        vectors++;
        if (obs_a !== exp) begin miscompares++; $display("FAIL hidden_abort: got %s expected %s", res_str(obs_a), res_str(exp)); end
        vectors++;
        if (obs_n !== exp) begin miscompares++; $display("FAIL hidden_full: got %s expected %s", res_str(obs_n), res_str(exp)); end
    endtask

    task automatic test_row_dup();
        res_t exp_a, exp_n;
        load_empty();
        cells[0] = 4'd7;
        cells[5] = 4'd7;
        run_scan(-1);
        exp_a = mk(1'b1, 1'b0, 0, 0, 5, 2, 7);
        exp_n = mk(1'b1, 1'b0, 0, 0, 5, 2, 244);
        vectors++;
        if (obs_a !== exp_a) begin miscompares++; $display("FAIL row_dup_abort: got %s expected %s", res_str(obs_a), res_str(exp_a)); end
        vectors++;
        if (obs_n !== exp_n) begin miscompares++; $display("FAIL row_dup_full: got %s expected %s", res_str(obs_n), res_str(exp_n)); end
    endtask

    task automatic test_col_dup();
        res_t exp_a, exp_n;
        load_empty();
        cells[1*9+2] = 4'd3;
        cells[6*9+2] = 4'd3;
        run_scan(-1);
        exp_a = mk(1'b1, 1'b0, 11, 6, 2, 2, 107);
        exp_n = mk(1'b1, 1'b0, 11, 6, 2, 2, 244);
        vectors++;
        if (obs_a !== exp_a) begin miscompares++; $display("FAIL col_dup_abort: got %s expected %s", res_str(obs_a), res_str(exp_a)); end
        vectors++;
        if (obs_n !== exp_n) begin miscompares++; $display("FAIL col_dup_full: got %s expected %s", res_str(obs_n), res_str(exp_n)); end
    endtask

    task automatic test_box_dup();
        res_t exp_a, exp_n;
        load_empty();
        cells[0] = 4'd5;
        cells[1*9+1] = 4'd5;
        run_scan(-1);
        exp_a = mk(1'b1, 1'b0, 18, 1, 1, 2, 168);
        exp_n = mk(1'b1, 1'b0, 18, 1, 1, 2, 244);
        vectors++;
        if (obs_a !== exp_a) begin miscompares++; $display("FAIL box_dup_abort: got %s expected %s", res_str(obs_a), res_str(exp_a)); end
        vectors++;
        if (obs_n !== exp_n) begin miscompares++; $display("FAIL box_dup_full: got %s expected %s", res_str(obs_n), res_str(exp_n)); end
    endtask

    task automatic test_illegal_and_reset();
        res_t exp_a, exp_n;
        bit   saw;
        load_empty();
        cells[80] = 4'd12;
        run_scan(9);
        exp_a = mk(1'b1, 1'b0, 8, 8, 8, 1, 82);
        exp_n = mk(1'b1, 1'b0, 8, 8, 8, 1, 244);
        vectors++;
        if (obs_a !== exp_a) begin miscompares++; $display("FAIL illegal_abort: got %s expected %s", res_str(obs_a), res_str(exp_a)); end
        vectors++;
        if (obs_n !== exp_n) begin miscompares++; $display("FAIL illegal_full: got %s expected %s", res_str(obs_n), res_str(exp_n)); end
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if ({a_done, a_busy, a_conflict, a_complete, a_grp, a_i, a_j, a_filled} !== {4'b0010, 5'd8, 4'd8, 4'd8, 7'd1}) begin
            miscompares++;
            $display("FAIL result_hold: conflict=%0d group=%0d i=%0d j=%0d filled=%0d expected 1/8/8/8/1", a_conflict, a_grp, a_i, a_j, a_filled);
        end
        apply();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (49) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        vectors++;
        if ({a_busy, a_done, a_complete, a_conflict, a_grp, a_i, a_j, a_filled} !== 24'd0) begin
            miscompares++;
            $display("FAIL midscan_reset_abort: outputs=%h expected 0", {a_busy, a_done, a_complete, a_conflict, a_grp, a_i, a_j, a_filled});
        end
        vectors++;
        if ({n_busy, n_done, n_complete, n_conflict, n_grp, n_i, n_j, n_filled} !== 24'd0) begin
            miscompares++;
            $display("FAIL midscan_reset_full: outputs=%h expected 0", {n_busy, n_done, n_complete, n_conflict, n_grp, n_i, n_j, n_filled});
        end
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        saw = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (a_done || n_done || a_busy || n_busy) saw = 1;
        end
        vectors++;
        if (saw !== 1'b0) begin
            miscompares++;
            $display("FAIL no_done_after_reset: activity=%0d expected 0", saw);
        end
    endtask

    task automatic test_random(input int runs);
        res_t exp_a, exp_n;
        int   mode;
        for (int r = 0; r < runs; r++) begin
            load_solved();
            for (int k = 0; k < 81; k++) vis[k] = (r % 3 == 0) ? 1'b1 : ($urandom_range(9, 0) != 0);
            mode = $urandom_range(3, 0);
            if (mode == 1 || mode == 3) cells[$urandom_range(80, 0)] = 4'($urandom_range(9, 1));
            if (mode == 2 || mode == 3) cells[$urandom_range(80, 0)] = 4'($urandom_range(15, 10));
            exp_a = model(1'b1);
            exp_n = model(1'b0);
            run_scan(-1);
            vectors++;
            if (obs_a !== exp_a) begin miscompares++; $display("FAIL random_abort run %0d: got %s expected %s", r, res_str(obs_a), res_str(exp_a)); end
            vectors++;
            if (obs_n !== exp_n) begin miscompares++; $display("FAIL random_full run %0d: got %s expected %s", r, res_str(obs_n), res_str(exp_n)); end
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        board = '0;
        visibilities = '0;
        ga_g = '0;
        ga_e = '0;
        test_reset();
        test_group_addr();
        test_solved_grid();
        test_hidden_cell();
        test_row_dup();
        test_col_dup();
        test_box_dup();
        test_illegal_and_reset();
        test_random(16);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/board_checker.md
Name: board_checker

Overview:
- Reads the 324-bit board and 81-bit visibility vectors that the game state machine writes, and validates them against Sudoku rules.
- On a start pulse it snapshots both vectors, then scans 27 groups (9 rows, 9 columns, 9 boxes) one cell per clock.
- Reports conflict location, filled-cell count and completion, which the state machine uses for win/error decisions.

Parameters:
- ABORT_ON_CONFLICT, 1: 1 = end the scan at the first duplicate; 0 = finish all 27 groups but keep only the first conflict.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request; sampled only in IDLE
- board  input  324  cell k = i*9+j occupies bits [4k+3:4k]; value 0 = empty, 1..9 = digit
- visibilities  input  81  bit k = 1: cell k is shown; 0: treated as empty
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; result outputs valid from this cycle
- complete  output  1  no conflict and filled_count == 81
- conflict  output  1  duplicate digit or illegal value (10..15) found
- conflict_group  output  5  group index 0..26 of the first conflict
- conflict_i, conflict_j  output  4 each  row/column of the first conflicting cell
- filled_count  output  7  number of visible non-zero cells, 0..81

Behaviour:
- Reset (asynchronous, active-low): FSM goes to IDLE; all outputs 0; snapshot, mask and counters cleared.
- Reset asserted mid-scan aborts the scan. No done pulse follows.
- States: IDLE, SCAN, DONE.
- IDLE, start=1: register board and visibilities into the snapshot.
  - Clear g, e, the 9-bit mask, the result registers and filled_count.
  - Next state SCAN; busy=1 on the next edge.
- SCAN: one cell per cycle at group g (0..26), element e (0..8).
  - Rows, g 0..8: i=g, j=e.
  - Columns, g 9..17: i=e, j=g-9.
  - Boxes, g 18..26: b=g-18; i=3*(b/3)+e/3; j=3*(b%3)+e%3.
  - Cell value v = snapshot value, or 0 if its visibility bit is 0.
  - v == 0: no action.
  - v in 10..15: conflict. Record g, i, j if no conflict is recorded yet.
  - mask[v-1] already set: conflict. Record as above.
  - Otherwise set mask[v-1].
  - filled_count increments only during row groups (g 0..8) when v is non-zero. Each cell is counted exactly once.
  - At e=8: clear mask, set e=0, increment g.
  - After g=26, e=8, or at the first conflict when ABORT_ON_CONFLICT=1, next state is DONE.
- DONE (one cycle): done=1, busy=0, complete computed; then IDLE.
  - On abort, filled_count holds only the partial count.
  - complete=0 whenever conflict=1.
- Latency: start accepted at edge 0; full scan = 243 SCAN cycles; done is high in cycle 244.
  - On abort at scan cycle n, done is high in cycle n+1.
- Result outputs hold their values until the next accepted start. The next start clears them.
- start in SCAN or DONE is ignored and not queued.
- Changes to board or visibilities during a scan have no effect, because the snapshot is used.
- Counter widths: g is 5 bits, e is 4 bits. Neither wraps in normal operation; g terminates at 26.

Decomposition:
- sudoku_pkg holds:
  - the FSM state enum;
  - constants N_CELLS=81, N_GROUPS=27, GROUP_SIZE=9, CELL_W=4;
  - the cell-index helper function k = i*9+j.
- Sub-module group_addr: combinational (g, e) -> (i, j) mapping, unit-tested in isolation.

Test Plan:
- Known solved grid, all visible, start pulse -> done in cycle 244; complete=1, conflict=0, filled_count=81.
- Solved grid with cell (4,4) visibility=0 -> done in cycle 244; complete=0, conflict=0, filled_count=80.
- Row 0 with digit 7 at (0,0) and (0,5), ABORT_ON_CONFLICT=1 -> done in cycle 7; conflict=1, group 0, i=0, j=5, complete=0.
- Only a column duplicate: 3 at (1,2) and (6,2), rows and boxes otherwise clean -> conflict_group=11, i=6, j=2.
- Only a box duplicate: 5 at (0,0) and (1,1), each in a different row and column -> conflict_group=18, i=1, j=1.
- Value 12 at (8,8); start re-pulsed at cycle 10; reset asserted in a second run at cycle 50:
  - first run: conflict at group 8, i=8, j=8; the extra start is ignored;
  - second run: all outputs return to 0, no done pulse.
